pe_stream_feeder: RTL
=====================

Name: pe_stream_feeder

Overview:
Parametrised multi-channel bus-side source that streams data words into PE input FIFOs (fmap, weight, psum) with FIFO-full backpressure. Each channel plays back programmable segments of incrementing data. Segments are separated either by a fixed gap or by a PE trigger such as shift_finish_flg. Each segment is preceded by a one-cycle load-start pulse. The block replaces ad-hoc bench-side feeding and serves as the array-level stimulus/bus engine driving one PE's load ports.

Parameters:
NUM_CH, 3, number of independent channels (e.g. 0 = fmap, 1 = weight, 2 = psum)
DATA_WIDTH, 16, data word width
CNT_WIDTH, 8, width of the length, segment-count and gap counters

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  NUM_CH  per-channel one-cycle start pulse
cfg_base  in  NUM_CH*DATA_WIDTH  first data value of the channel
cfg_len  in  NUM_CH*CNT_WIDTH  words per segment
cfg_seg  in  NUM_CH*CNT_WIDTH  number of segments
cfg_gap  in  NUM_CH*CNT_WIDTH  idle cycles between segments (when trig_mode=0)
cfg_trig_mode  in  NUM_CH  1 = next segment waits for seg_trig instead of gap
seg_trig  in  NUM_CH  per-channel segment-release trigger (level)
fifo_full  in  NUM_CH  per-channel PE FIFO full (backpressure)
load_start  out  NUM_CH  one-cycle pulse announcing a segment (to start_*_load)
data_out  out  NUM_CH*DATA_WIDTH  per-channel data word
data_en  out  NUM_CH  data valid; word accepted when data_en & !fifo_full
busy  out  NUM_CH  channel active
done  out  NUM_CH  one-cycle pulse after the last word of the last segment is accepted

Behaviour:
- Config is sampled into channel registers on the start pulse. Later config changes do not affect a running channel.
- Reset (rst=0, asynchronous): every channel goes to IDLE. load_start=0, data_en=0, data_out=0, busy=0, done=0, all counters cleared. Reset mid-stream discards the remaining words; no done pulse is produced.
- Per-channel FSM states:
  - IDLE: on start with len!=0 and seg!=0, go to PULSE and set busy=1. On start with len==0 or seg==0, pulse done on the next cycle and stay in IDLE. start in any other state is ignored.
  - PULSE: load_start=1 for exactly one cycle, then STREAM.
  - STREAM: data_en=1. A word transfers on a posedge where data_en=1 and fifo_full=0. data_out increments by 1 after each transfer. While full, data_out and data_en hold with no loss or duplication. After the last word of a segment:
    - last segment: go to IDLE, done=1 for one cycle, busy=0 in the same cycle.
    - else if trig_mode=1: go to WAIT_TRIG.
    - else if gap==0: go to PULSE.
    - else: go to GAP.
  - GAP: data_en=0; count cfg_gap cycles, then PULSE.
  - WAIT_TRIG: data_en=0; seg_trig is sampled only in this state (level). When it is high, go to PULSE. A trigger asserted in any other state is not remembered.
- Data sequence: word k of segment s = base + s*len + k, modulo 2^DATA_WIDTH (wraps without error).
- Latency: start sampled at edge n, load_start high after edge n+1, first data_en high after edge n+2. Back-to-back transfers at one word per cycle when not full.
- data_en is registered and does not depend combinationally on fifo_full. The PE FIFO must tolerate data_en held high while full, without taking the word.
- Channels are fully independent. Simultaneous starts, triggers and backpressure on different channels do not interact.
- fifo_full rising in the same cycle as the last word: the word is not accepted and the segment end waits for acceptance.

Test Plan:
- ch0 base=1 len=6 seg=1, full=0, start -> load_start one cycle, then data_out 1..6 on 6 consecutive cycles with data_en=1. done pulses the cycle after word 6; busy falls then.
- Same config, fifo_full high during the cycle word 3 is presented, for 2 cycles -> word 3 held 3 cycles. Accepted sequence is exactly 1,2,3,4,5,6.
- ch1 base=1 len=9 seg=2 gap=60 trig_mode=0 -> words 1..9, then 60 cycles with data_en=0. Second load_start, then words 10..18, then done.
- ch0 base=13 len=12 seg=2 trig_mode=1, seg_trig pulsed during segment 1 and again 10 cycles after it ends -> first pulse ignored. Second load_start occurs the cycle after the second trigger, then words 25..36.
- ch0 and ch1 started in the same cycle (len 6 and 9), with ch1 full toggling -> ch0 finishes after 6+2 cycles unaffected. ch1 sequence is intact.
- Reset asserted mid-segment -> all outputs 0 immediately and no done pulse. start with len=0 -> done the next cycle, and load_start and data_en never assert.

Source files
------------

// File: rtl/pe_stream_feeder_if.sv
// Stream bus between the feeder and one PE's load ports: per-channel load-start
// pulse, data word with valid, and FIFO-full backpressure from the PE.
interface pe_stream_feeder_if #(
  parameter int NUM_CH     = 3,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_CH-1:0]            load_start;
  logic [NUM_CH*DATA_WIDTH-1:0] data_out;
  logic [NUM_CH-1:0]            data_en;
  logic [NUM_CH-1:0]            fifo_full;

  modport master (output load_start, data_out, data_en, input fifo_full);
  modport slave  (input load_start, data_out, data_en, output fifo_full);
endinterface

// File: rtl/pe_stream_feeder.sv
// Multi-channel segment player: each channel streams incrementing words in
// segments separated by a fixed gap or a PE trigger, with FIFO-full backpressure.
module pe_stream_feeder #(
  parameter int NUM_CH     = 3,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           start,
  input  logic [NUM_CH*DATA_WIDTH-1:0] cfg_base,
  input  logic [NUM_CH*CNT_WIDTH-1:0] cfg_len,
  input  logic [NUM_CH*CNT_WIDTH-1:0] cfg_seg,
  input  logic [NUM_CH*CNT_WIDTH-1:0] cfg_gap,
  input  logic [NUM_CH-1:0]           cfg_trig_mode,
  input  logic [NUM_CH-1:0]           seg_trig,
  pe_stream_feeder_if.master          bus,
  output logic [NUM_CH-1:0]           busy,
  output logic [NUM_CH-1:0]           done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_PULSE,
    ST_STREAM,
    ST_GAP,
    ST_WAIT_TRIG
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = 1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t                 state_reg, state_next;
      logic [CNT_WIDTH-1:0]   len_reg, len_next;
      logic [CNT_WIDTH-1:0]   seg_reg, seg_next;
      logic [CNT_WIDTH-1:0]   gap_reg, gap_next;
      logic [CNT_WIDTH-1:0]   word_cnt_reg, word_cnt_next;
      logic [CNT_WIDTH-1:0]   seg_cnt_reg, seg_cnt_next;
      logic [CNT_WIDTH-1:0]   gap_cnt_reg, gap_cnt_next;
      logic                   trig_mode_reg, trig_mode_next;
      logic                   done_reg, done_next;
      logic [DATA_WIDTH-1:0]  data_reg, data_next;
      logic [CNT_WIDTH-1:0]   start_len, start_seg;

      assign start_len = cfg_len[gi*CNT_WIDTH +: CNT_WIDTH];
      assign start_seg = cfg_seg[gi*CNT_WIDTH +: CNT_WIDTH];

      always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        seg_next       = seg_reg;
        gap_next       = gap_reg;
        word_cnt_next  = word_cnt_reg;
        seg_cnt_next   = seg_cnt_reg;
        gap_cnt_next   = gap_cnt_reg;
        trig_mode_next = trig_mode_reg;
        data_next      = data_reg;
        done_next      = 1'b0;
        case (state_reg)
          ST_IDLE: begin
            if (start[gi]) begin
              len_next       = start_len;
              seg_next       = start_seg;
              gap_next       = cfg_gap[gi*CNT_WIDTH +: CNT_WIDTH];
              trig_mode_next = cfg_trig_mode[gi];
              data_next      = cfg_base[gi*DATA_WIDTH +: DATA_WIDTH];
              word_cnt_next  = '0;
              seg_cnt_next   = '0;
              gap_cnt_next   = '0;
              if (start_len == '0 || start_seg == '0) begin
                done_next = 1'b1;
              end else begin
                state_next = ST_ARM;
              end
            end
          end
          // One settling cycle so the first load_start lands two edges after start.
          ST_ARM:   state_next = ST_PULSE;
          ST_PULSE: begin
            word_cnt_next = '0;
            state_next    = ST_STREAM;
          end
          ST_STREAM: begin
            if (!bus.fifo_full[gi]) begin
              data_next = data_reg + DATA_ONE;
              if (word_cnt_reg == len_reg - CNT_ONE) begin
                word_cnt_next = '0;
                if (seg_cnt_reg == seg_reg - CNT_ONE) begin
                  state_next = ST_IDLE;
                  done_next  = 1'b1;
                end else begin
                  seg_cnt_next = seg_cnt_reg + CNT_ONE;
                  gap_cnt_next = '0;
                  if (trig_mode_reg)        state_next = ST_WAIT_TRIG;
                  else if (gap_reg == '0)   state_next = ST_PULSE;
                  else                      state_next = ST_GAP;
                end
              end else begin
                word_cnt_next = word_cnt_reg + CNT_ONE;
              end
            end
          end
          ST_GAP: begin
            if (gap_cnt_reg == gap_reg - CNT_ONE) state_next = ST_PULSE;
            else                                  gap_cnt_next = gap_cnt_reg + CNT_ONE;
          end
          ST_WAIT_TRIG: begin
            if (seg_trig[gi]) state_next = ST_PULSE;
          end
          default: state_next = ST_IDLE;
        endcase
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_reg     <= ST_IDLE;
          len_reg       <= '0;
          seg_reg       <= '0;
          gap_reg       <= '0;
          word_cnt_reg  <= '0;
          seg_cnt_reg   <= '0;
          gap_cnt_reg   <= '0;
          trig_mode_reg <= 1'b0;
          done_reg      <= 1'b0;
          data_reg      <= '0;
        end else begin
          state_reg     <= state_next;
          len_reg       <= len_next;
          seg_reg       <= seg_next;
          gap_reg       <= gap_next;
          word_cnt_reg  <= word_cnt_next;
          seg_cnt_reg   <= seg_cnt_next;
          gap_cnt_reg   <= gap_cnt_next;
          trig_mode_reg <= trig_mode_next;
          done_reg      <= done_next;
          data_reg      <= data_next;
        end
      end

      // Outputs decode straight from registered state; no path from fifo_full.
      assign bus.load_start[gi] = (state_reg == ST_PULSE);
      assign bus.data_en[gi]    = (state_reg == ST_STREAM);
      assign bus.data_out[gi*DATA_WIDTH +: DATA_WIDTH] =
        (state_reg == ST_STREAM) ? data_reg : '0;
      assign busy[gi] = (state_reg != ST_IDLE);
      assign done[gi] = done_reg;
    end
  endgenerate

endmodule
